// File: rtl/uart_program_loader_if.sv
// Programmer write port: the loader drives it, the instruction/data memory split consumes it.
interface uart_program_loader_if;
    logic        oUpgWriteEnable;
    logic [14:0] oUpgAddress;
    logic [31:0] oUpgData;
    logic        oUpgDone;
    logic        oFrameError;

    modport master (
        output oUpgWriteEnable,
        output oUpgAddress,
        output oUpgData,
        output oUpgDone,
        output oFrameError
    );

    modport slave (
        input oUpgWriteEnable,
        input oUpgAddress,
        input oUpgData,
        input oUpgDone,
        input oFrameError
    );
endinterface

// File: rtl/uart_program_loader.sv
// UART 8N1 boot loader: receives bytes, packs them big-endian into 32-bit words and
// issues one write strobe per word until the whole image has been loaded.
module uart_program_loader #(
    parameter int CLK_HZ      = 10_000_000,
    parameter int BAUD        = 128_000,
    parameter int TOTAL_WORDS = 32768
) (
    input  logic                         iUpgClock,
    input  logic                         iUpgResetN,
    input  logic                         iUartRx,
    uart_program_loader_if.master        upg
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] HALF     = CW'(DIV / 2);
    localparam logic [CW-1:0] LAST     = CW'(DIV - 1);
    localparam logic [15:0]   IDX_FULL = 16'(TOTAL_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    state_e      state_q, state_d;
    logic        rx_meta_q, rx_meta_d;
    logic        rx_sync_q, rx_sync_d;
    logic        rx_prev_q, rx_prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [23:0] word_q, word_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0] idx_q, idx_d;
    logic        we_q, we_d;
    logic [14:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        done_q, done_d;
    logic        fe_q, fe_d;
    logic        byte_ok;
    logic        full;

    // The receiver freezes as soon as the last word index has been consumed, one
    // cycle before done is visible, so no new frame can start in that gap.
    assign full = (idx_q == IDX_FULL);

    always_comb begin
        state_d    = state_q;
        rx_meta_d  = iUartRx;
        rx_sync_d  = rx_meta_q;
        rx_prev_d  = rx_sync_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        word_d     = word_q;
        byte_cnt_d = byte_cnt_q;
        idx_d      = idx_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        fe_d       = 1'b0;
        byte_ok    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!full && rx_prev_q && !rx_sync_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF) begin
                    cnt_d = '0;
                    bit_d = 3'd0;
                    state_d = rx_sync_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (rx_sync_q) byte_ok = 1'b1;
                    else           fe_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Bytes shift in from the bottom so the first byte ends up in [31:24].
        if (byte_ok) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            word_d     = {word_q[15:0], shift_q};
            if (byte_cnt_q == 2'd3) begin
                we_d   = 1'b1;
                data_d = {word_q, shift_q};
                addr_d = idx_q[14:0];
                idx_d  = idx_q + 16'd1;
            end
        end

        done_d = done_q | (we_q && full);
    end

    always_ff @(posedge iUpgClock or negedge iUpgResetN) begin
        if (!iUpgResetN) begin
            state_q    <= S_IDLE;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            word_q     <= '0;
            byte_cnt_q <= '0;
            idx_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            fe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_meta_q  <= rx_meta_d;
            rx_sync_q  <= rx_sync_d;
            rx_prev_q  <= rx_prev_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_d;
            idx_q      <= idx_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            done_q     <= done_d;
            fe_q       <= fe_d;
        end
    end

    assign upg.oUpgWriteEnable = we_q;
    assign upg.oUpgAddress     = addr_q;
    assign upg.oUpgData        = data_q;
    assign upg.oUpgDone        = done_q;
    assign upg.oFrameError     = fe_q;

endmodule
